// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the key schedule
// and the cipher datapath.
package aes_pkg;

  localparam int NR = 10;

  typedef logic [7:0]  ByteType;
  typedef logic [31:0] aes_word;
  // Element 0 is the most significant word (w0 = bits [127:96]).
  typedef aes_word [0:3] key_128;

  localparam ByteType RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_DONE
  } state_e;

  function automatic ByteType xtime(input ByteType x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte, purely combinational.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam ByteType SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_o = SBOX[in_i];

endmodule

// File: rtl/aes_key_expand_seq.sv
// AES-128 key schedule, one round key per cycle, with an 11-entry round-key
// bank read by index through a one-cycle registered port.
module aes_key_expand_seq
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid_i,
  output logic         key_ready_o,
  input  logic [127:0] key_i,
  input  logic [3:0]   rk_rd_idx_i,
  output logic [127:0] rk_o,
  output logic         keys_ready_o,
  output logic         busy_o,
  output logic [3:0]   round_o
);

  state_e       state_q, state_d;
  key_128       w_q, w_d;
  ByteType      rcon_q, rcon_d;
  logic [3:0]   round_q, round_d;
  logic         keys_ready_q, keys_ready_d;
  logic [127:0] rk_q, rk_d;
  key_128       bank_q [NR+1];
  key_128       bank_d [NR+1];

  aes_word rot_w, sub_w, t_w;
  key_128  w_next;
  logic    accept;

  // RotWord: {b1,b2,b3,b0}, then SubWord byte by byte.
  assign rot_w = {w_q[3][23:0], w_q[3][31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (rot_w[8*i +: 8]),
      .out_o (sub_w[8*i +: 8])
    );
  end

  assign t_w       = sub_w ^ {rcon_q, 24'h0};
  assign w_next[0] = w_q[0] ^ t_w;
  assign w_next[1] = w_q[1] ^ w_next[0];
  assign w_next[2] = w_q[2] ^ w_next[1];
  assign w_next[3] = w_q[3] ^ w_next[2];

  // Key handshake: a key transfers on any rising edge where key_valid_i and
  // key_ready_o are both high; key_ready_o is low only while expanding, and
  // key_i need not be held after the transfer edge.
  assign key_ready_o = (state_q != ST_EXPAND);
  assign accept      = key_valid_i & key_ready_o;

  always_comb begin
    state_d      = state_q;
    w_d          = w_q;
    rcon_d       = rcon_q;
    round_d      = round_q;
    keys_ready_d = keys_ready_q;
    bank_d       = bank_q;
    rk_d         = '0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          bank_d[0]    = key_i;
          w_d          = key_i;
          round_d      = 4'd1;
          rcon_d       = RCON_INIT;
          keys_ready_d = 1'b0;
          state_d      = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        bank_d[round_q] = w_next;
        w_d             = w_next;
        rcon_d          = xtime(rcon_q);
        if (round_q == 4'(NR)) begin
          state_d      = ST_DONE;
          keys_ready_d = 1'b1;
          round_d      = 4'd0;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Reads see bank_q, so a same-edge write returns the old entry.
    if (rk_rd_idx_i <= 4'(NR)) begin
      rk_d = bank_q[rk_rd_idx_i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      w_q          <= '0;
      rcon_q       <= RCON_INIT;
      round_q      <= 4'd0;
      keys_ready_q <= 1'b0;
      rk_q         <= '0;
      bank_q       <= '{default: '0};
    end else begin
      state_q      <= state_d;
      w_q          <= w_d;
      rcon_q       <= rcon_d;
      round_q      <= round_d;
      keys_ready_q <= keys_ready_d;
      rk_q         <= rk_d;
      bank_q       <= bank_d;
    end
  end

  assign busy_o       = (state_q == ST_EXPAND);
  assign round_o      = round_q;
  assign keys_ready_o = keys_ready_q;
  assign rk_o         = rk_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Directed bench for aes_key_expand_seq using FIPS-197 and all-zero key schedules.
module tb_aes_key_expand_seq;

  logic         clk;
  logic         rst;
  logic         key_valid_i;
  logic         key_ready_o;
  logic [127:0] key_i;
  logic [3:0]   rk_rd_idx_i;
  logic [127:0] rk_o;
  logic         keys_ready_o;
  logic         busy_o;
  logic [3:0]   round_o;

  aes_key_expand_seq dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid_i  (key_valid_i),
    .key_ready_o  (key_ready_o),
    .key_i        (key_i),
    .rk_rd_idx_i  (rk_rd_idx_i),
    .rk_o         (rk_o),
    .keys_ready_o (keys_ready_o),
    .busy_o       (busy_o),
    .round_o      (round_o)
  );

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;

  vec_t         fips_tab [11];
  vec_t         zero_tab [3];
  logic [127:0] exp_q [$];
  int           n_checks;
  int           n_bad;

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic accept_key(input logic [127:0] k);
    @(negedge clk);
    key_i       = k;
    key_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_valid_i = 1'b0;
    key_i       = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!keys_ready_o && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!keys_ready_o) begin
      n_checks++;
      n_bad++;
      $display("FAIL wait_done: keys_ready_o never rose within %0d cycles", cyc);
    end
  endtask

  task automatic read_rk(input logic [3:0] idx, output logic [127:0] data);
    @(negedge clk);
    rk_rd_idx_i = idx;
    @(negedge clk);
    data = rk_o;
  endtask

  // Scoreboard: push each expected value, then compare against the read.
  task automatic read_and_score(input string name, input logic [3:0] idx, input logic [127:0] exp);
    logic [127:0] got;
    exp_q.push_back(exp);
    read_rk(idx, got);
    chk($sformatf("%s[%0d]", name, idx), got, exp_q.pop_front());
  endtask

  initial begin
    int           cyc;
    logic [127:0] got;

    n_checks = 0;
    n_bad    = 0;

    fips_tab[0]  = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    fips_tab[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    fips_tab[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    fips_tab[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    fips_tab[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    fips_tab[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    fips_tab[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    fips_tab[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    fips_tab[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    fips_tab[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    fips_tab[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    zero_tab[0] = '{4'd0,  128'h0};
    zero_tab[1] = '{4'd1,  ZERO_RK1};
    zero_tab[2] = '{4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    rst         = 1'b1;
    key_valid_i = 1'b0;
    key_i       = '0;
    rk_rd_idx_i = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_key_ready", {127'b0, key_ready_o}, 128'd1);
    chk("rst_busy", {127'b0, busy_o}, 128'd0);
    chk("rst_keys_ready", {127'b0, keys_ready_o}, 128'd0);
    chk("rst_round", {124'b0, round_o}, 128'd0);
    chk("rst_rk", rk_o, 128'd0);
    read_and_score("rst_bank", 4'd5, 128'd0);

    // FIPS-197 key: latency and full schedule
    accept_key(FIPS_KEY);
    chk("fips_busy_after_accept", {127'b0, busy_o}, 128'd1);
    chk("fips_round_after_accept", {124'b0, round_o}, 128'd1);
    chk("fips_ready_after_accept", {127'b0, key_ready_o}, 128'd0);
    wait_done(cyc);
    chk("fips_latency_edges", 128'(cyc + 1), 128'd11);
    chk("fips_busy_done", {127'b0, busy_o}, 128'd0);
    chk("fips_round_done", {124'b0, round_o}, 128'd0);
    for (int i = 0; i < 11; i++) read_and_score("fips_rk", fips_tab[i].idx, fips_tab[i].exp);

    // Out-of-range indices read as zero
    for (int i = 11; i < 16; i++) read_and_score("oob_rk", 4'(i), 128'd0);

    // Second key accepted in DONE; rk[0] read on the accepting edge returns the old key
    @(negedge clk);
    rk_rd_idx_i = 4'd0;
    accept_key(128'h0);
    chk("k2_keys_ready_drop", {127'b0, keys_ready_o}, 128'd0);
    chk("k2_rk0_old_on_write", rk_o, FIPS_KEY);
    @(negedge clk);
    chk("k2_rk0_new", rk_o, 128'h0);
    wait_done(cyc);
    chk("k2_latency_edges", 128'(cyc + 2), 128'd11);
    for (int i = 0; i < 3; i++) read_and_score("zero_rk", zero_tab[i].idx, zero_tab[i].exp);

    // Same-entry read/write during EXPAND, and a key pulse that must be ignored
    accept_key(FIPS_KEY);
    rk_rd_idx_i = 4'd1;
    key_valid_i = 1'b1;
    key_i       = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    chk("pulse_key_ready_low", {127'b0, key_ready_o}, 128'd0);
    @(negedge clk);
    key_valid_i = 1'b0;
    chk("rw_same_edge_old", rk_o, ZERO_RK1);
    chk("pulse_round2", {124'b0, round_o}, 128'd2);
    @(negedge clk);
    chk("rw_next_read_new", rk_o, fips_tab[1].exp);
    wait_done(cyc);
    read_and_score("pulse_rk", 4'd5, fips_tab[5].exp);
    read_and_score("pulse_rk", 4'd10, fips_tab[10].exp);

    // Asynchronous reset at round 5, then re-accept from scratch
    accept_key(128'h0);
    repeat (4) @(negedge clk);
    chk("pre_rst_round5", {124'b0, round_o}, 128'd5);
    rst = 1'b1;
    #1;
    chk("midrst_key_ready", {127'b0, key_ready_o}, 128'd1);
    chk("midrst_busy", {127'b0, busy_o}, 128'd0);
    chk("midrst_keys_ready", {127'b0, keys_ready_o}, 128'd0);
    chk("midrst_round", {124'b0, round_o}, 128'd0);
    chk("midrst_rk", rk_o, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    read_and_score("post_rst_bank", 4'd10, 128'd0);
    accept_key(FIPS_KEY);
    wait_done(cyc);
    chk("rerun_latency_edges", 128'(cyc + 1), 128'd11);
    read_and_score("rerun_rk", 4'd4, fips_tab[4].exp);
    read_and_score("rerun_rk", 4'd10, fips_tab[10].exp);

    // Final report
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
